// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends 0x80, zero fill and the 64-bit length.
// Optional length-limit check enabled by defining SHA_PAD_LEN_CHECK_EN (sticky overflow_o, saturating count).
module sha256_msg_padder #(
    parameter int BYTE_CNT_W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [7:0]   data_i,
    input  logic         data_valid_i,
    input  logic         data_last_i,
    output logic         data_rdy_o,
    output logic [511:0] block_o,
    output logic         block_valid_o,
    output logic         block_last_o,
    input  logic         block_rdy_i,
    output logic         msg_done_o,
    output logic         overflow_o
);

    typedef enum logic [1:0] {S_FILL, S_OUT, S_XTRA} state_t;
    typedef enum logic [1:0] {P_NONE, P_LEN, P_PAD} pend_t;

    state_t                state;
    pend_t                 pend;
    logic [5:0]            ptr;
    logic [BYTE_CNT_W-1:0] cnt;

    logic                  sat;
    logic                  keep;
    logic [BYTE_CNT_W-1:0] cnt_nxt;
    logic [6:0]            n;
    logic [63:0]           len_fill;
    logic [63:0]           len_hold;
    logic [511:0]          fill_blk;
    logic [511:0]          xtra_blk;

`ifdef SHA_PAD_LEN_CHECK_EN
    assign sat = (cnt == {BYTE_CNT_W{1'b1}});
`else
    assign sat = 1'b0;
`endif

    assign data_rdy_o = (state == S_FILL);
    assign keep       = !sat;
    assign cnt_nxt    = sat ? cnt : cnt + BYTE_CNT_W'(1);
    assign n          = {1'b0, ptr} + {6'b000000, keep};
    assign len_fill   = 64'(cnt_nxt) << 3;
    assign len_hold   = 64'(cnt) << 3;
    assign xtra_blk   = {(pend == P_PAD) ? 8'h80 : 8'h00, 440'd0, len_hold};

    // Bytes past the pointer are already zero because the register clears after every handshake.
    always_comb begin
        fill_blk = block_o;
        if (keep)
            fill_blk[9'd511 - {ptr, 3'b000} -: 8] = data_i;
        if (data_last_i) begin
            if (n < 7'd64)
                fill_blk[9'd511 - {n[5:0], 3'b000} -: 8] = 8'h80;
            if (n <= 7'd55)
                fill_blk[63:0] = len_fill;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_FILL;
            pend          <= P_NONE;
            ptr           <= '0;
            cnt           <= '0;
            block_o       <= '0;
            block_valid_o <= 1'b0;
            block_last_o  <= 1'b0;
            msg_done_o    <= 1'b0;
`ifdef SHA_PAD_LEN_CHECK_EN
            overflow_o    <= 1'b0;
`endif
        end else begin
            msg_done_o <= 1'b0;
            case (state)
                S_FILL: begin
                    if (data_valid_i) begin
                        cnt     <= cnt_nxt;
                        block_o <= fill_blk;
`ifdef SHA_PAD_LEN_CHECK_EN
                        if (sat)
                            overflow_o <= 1'b1;
`endif
                        if (data_last_i) begin
                            state         <= S_OUT;
                            block_valid_o <= 1'b1;
                            if (n <= 7'd55) begin
                                block_last_o <= 1'b1;
                            end else begin
                                // Length does not fit: a second block carries it.
                                block_last_o <= 1'b0;
                                pend         <= (n == 7'd64) ? P_PAD : P_LEN;
                            end
                        end else if (keep && ptr == 6'd63) begin
                            state         <= S_OUT;
                            block_valid_o <= 1'b1;
                            block_last_o  <= 1'b0;
                            ptr           <= '0;
                        end else begin
                            ptr <= ptr + {5'b00000, keep};
                        end
                    end
                end
                S_OUT: begin
                    if (block_rdy_i) begin
                        block_valid_o <= 1'b0;
                        block_o       <= '0;
                        ptr           <= '0;
                        if (block_last_o) begin
                            block_last_o <= 1'b0;
                            msg_done_o   <= 1'b1;
                            cnt          <= '0;
                            state        <= S_FILL;
                        end else if (pend != P_NONE) begin
                            state <= S_XTRA;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end
                S_XTRA: begin
                    block_o       <= xtra_blk;
                    block_valid_o <= 1'b1;
                    block_last_o  <= 1'b1;
                    pend          <= P_NONE;
                    state         <= S_OUT;
                end
                default: state <= S_FILL;
            endcase
        end
    end

`ifndef SHA_PAD_LEN_CHECK_EN
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: random/directed messages, reference padding built from byte queues.
module tb_sha256_msg_padder;

`ifdef SHA_PAD_LEN_CHECK_EN
    localparam int W      = 6;
    localparam bit OVF_EN = 1'b1;
`else
    localparam int W      = 16;
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [7:0]   data_i;
    logic         data_valid_i;
    logic         data_last_i;
    logic         data_rdy_o;
    logic [511:0] block_o;
    logic         block_valid_o;
    logic         block_last_o;
    logic         block_rdy_i;
    logic         msg_done_o;
    logic         overflow_o;

    sha256_msg_padder #(.BYTE_CNT_W(W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .data_i(data_i), .data_valid_i(data_valid_i),
        .data_last_i(data_last_i), .data_rdy_o(data_rdy_o), .block_o(block_o),
        .block_valid_o(block_valid_o), .block_last_o(block_last_o), .block_rdy_i(block_rdy_i),
        .msg_done_o(msg_done_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         last;
        logic [511:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   msgs_sent = 0;
    int   done_seen = 0;
    bit   ovf_exp = 1'b0;
    bit   hold_rdy = 1'b0;

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: FIPS 180-4 padding on a byte queue, then sliced into 64-byte blocks.
    task automatic push_expect(input byte unsigned kept[$], input longint unsigned len_bits);
        byte unsigned p[$];
        exp_t         e;
        int           nblk;
        p = kept;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(len_bits >> (8 * i)));
        nblk = p.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < 64; j++) e.data[511 - 8 * j -: 8] = p[64 * k + j];
            e.last = (k == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_accept();
        int t = 0;
        @(negedge clk);
        while (!data_rdy_o && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!data_rdy_o) begin
            failures++;
            $display("FAIL accept_timeout: got data_rdy_o=0 expected 1");
            finish_run();
        end
        @(posedge clk);
        #1;
    endtask

    // kind: 0 random bytes, 1 "abc", 2 all zero
    task automatic send_msg(input int len, input int kind);
        byte unsigned msg[$];
        byte unsigned kept[$];
        bit           ovf_step[$];
        int           cntm = 0;
        for (int i = 0; i < len; i++) begin
            if (kind == 1)      msg.push_back(8'(8'h61 + i));
            else if (kind == 2) msg.push_back(8'h00);
            else                msg.push_back(8'($urandom));
        end
        for (int i = 0; i < len; i++) begin
            if (OVF_EN && cntm == MAX) begin
                ovf_exp = 1'b1;
            end else begin
                kept.push_back(msg[i]);
                cntm = (cntm + 1) % (MAX + 1);
            end
            ovf_step.push_back(ovf_exp);
        end
        push_expect(kept, longint'(cntm) * 8);
        msgs_sent++;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                data_valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            data_i       = msg[i];
            data_valid_i = 1'b1;
            data_last_i  = (i == len - 1);
            wait_accept();
            data_valid_i = 1'b0;
            data_last_i  = 1'b0;
            chk("overflow", overflow_o, ovf_step[i]);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d blocks pending expected 0", exp_q.size());
            finish_run();
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_block", block_o, '0);
        chk("rst_valid", block_valid_o, 0);
        chk("rst_last", block_last_o, 0);
        chk("rst_done", msg_done_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_data_rdy", data_rdy_o, 1);
    endtask

    // Downstream ready: random unless a test forces backpressure.
    initial begin
        block_rdy_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            block_rdy_i = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops the scoreboard on each block handshake, checks hold stability and done pulse.
    initial begin
        exp_t         e;
        bit           done_exp = 1'b0;
        bit           prev_hold = 1'b0;
        logic [511:0] prev_blk = '0;
        logic         prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                prev_hold = 1'b0;
                done_exp  = 1'b0;
            end else begin
                if (done_exp || msg_done_o) chk("msg_done", msg_done_o, done_exp);
                if (msg_done_o) done_seen++;
                done_exp = 1'b0;
                if (prev_hold) begin
                    chk("hold_valid", block_valid_o, 1);
                    chk("hold_data", block_o, prev_blk);
                    chk("hold_last", block_last_o, prev_last);
                end
                if (block_valid_o) chk("rdy_while_valid", data_rdy_o, 0);
                if (block_valid_o && block_rdy_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_block: got %0h expected none", block_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("block_data", block_o, e.data);
                        chk("block_last", block_last_o, e.last);
                        if (e.last) done_exp = 1'b1;
                    end
                end
                prev_hold = block_valid_o && !block_rdy_i;
                prev_blk  = block_o;
                prev_last = block_last_o;
            end
        end
    end

    initial begin
        rst_ni       = 1'b0;
        data_i       = 8'h00;
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_ni = 1'b1;

        send_msg(3, 1);
        send_msg(55, 2);
        send_msg(56, 2);
        send_msg(64, 2);
        send_msg(63, 0);
        send_msg(119, 0);
        send_msg(120, 0);
        send_msg(128, 0);

        // Backpressure: downstream stalls while the sender keeps offering bytes.
        hold_rdy = 1'b1;
        fork
            send_msg(70, 0);
            begin
                int t = 0;
                while (!block_valid_o && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_valid_seen", block_valid_o, 1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_data_rdy", data_rdy_o, 0);
                end
                hold_rdy = 1'b0;
            end
        join
        send_msg(20, 0);
        send_msg(100, 0);

        for (int m = 0; m < 10; m++) send_msg($urandom_range(1, 150), 0);
        wait_drain();

        // Reset in the middle of a message: partial block must vanish.
        for (int i = 0; i < 10; i++) begin
            data_i       = 8'($urandom);
            data_valid_i = 1'b1;
            data_last_i  = 1'b0;
            wait_accept();
            data_valid_i = 1'b0;
        end
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs();
        ovf_exp = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        send_msg(3, 1);
        wait_drain();
        chk("done_count", done_seen, msgs_sent);
        finish_run();
    end

endmodule
